// File: rtl/sram_pkg.sv
// Shared types, constants and elaboration helpers for the 1R1W masked SRAM model.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_pkg;

    // Galois LFSR used for the garbage-read pattern (right-shifting form).
    localparam logic [31:0] SRAM_LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] SRAM_LFSR_SEED = 32'h0000_0001;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } init_state_t;

    // Ceiling log2, minimum 1 so a 2-entry array still gets a 1-bit address.
    function automatic int sram_clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Geometry/latency legality, evaluated at elaboration by the top level.
    function automatic bit sram_cfg_ok(input int depth, input int data_width,
                                       input int mask_width, input int read_latency);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (mask_width > 0) && ((data_width % mask_width) == 0) &&
               ((read_latency == 1) || (read_latency == 2));
    endfunction

    function automatic logic [31:0] sram_lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ SRAM_LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset init sequencer: optional zero sweep of every entry, then RUN.
// Latency: init_done rises DEPTH cycles after reset (1 cycle when INIT_ZERO = 0).
// Backpressure: none; the sweep owns the write port while init_done is low.
//
// Ports: clock/reset (sync, active-high); init_done; sweep_en/sweep_addr drive
// the array write port with all-zero data during the sweep.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int INIT_ZERO = 1,
    parameter int AW        = sram_clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          init_done,
    output logic          sweep_en,
    output logic [AW-1:0] sweep_addr
);

    init_state_t   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_en = 1'b0;
        if (state_q == INIT && !reset) begin
            if (INIT_ZERO != 0) begin
                sweep_en = 1'b1;
                // The counter wraps back to 0 on the final entry, the same edge we leave INIT.
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end else begin
                state_d = RUN;
            end
        end
    end

    assign sweep_addr = cnt_q;
    assign init_done  = (state_q == RUN);

endmodule

// File: rtl/sram_1r1w_masked_ext.sv
// Behavioural 1R1W SRAM with per-granule write mask, collision policy and init sweep.
// Latency: READ_LATENCY (1 or 2) cycles from R0_en to R0_data, fully pipelined.
// Backpressure: none; accesses presented while init_done is low are dropped.
//
// Ports: clock, reset (sync, active-high), init_done; read port R0_en/R0_addr/R0_data;
// write port W0_en/W0_addr/W0_mask/W0_data (mask bit i covers granule [i*G +: G]).
// Build option: define SRAM_GARBAGE_READ_EN to drive an LFSR pattern on R0_data in
// every cycle with no completing read; otherwise R0_data holds its last value.
module sram_1r1w_masked_ext
    import sram_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int DATA_WIDTH   = 786,
    parameter int MASK_WIDTH   = 6,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1,
    parameter int INIT_ZERO    = 1,
    localparam int AW          = sram_clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  init_done,
    input  logic                  R0_en,
    input  logic [AW-1:0]         R0_addr,
    output logic [DATA_WIDTH-1:0] R0_data,
    input  logic                  W0_en,
    input  logic [AW-1:0]         W0_addr,
    input  logic [MASK_WIDTH-1:0] W0_mask,
    input  logic [DATA_WIDTH-1:0] W0_data
);

    localparam int G = DATA_WIDTH / MASK_WIDTH;

    if (!sram_cfg_ok(DEPTH, DATA_WIDTH, MASK_WIDTH, READ_LATENCY)) begin : g_bad_cfg
        $error("sram_1r1w_masked_ext: illegal DEPTH/DATA_WIDTH/MASK_WIDTH/READ_LATENCY");
    end

    logic                  sweep_en;
    logic [AW-1:0]         sweep_addr;
    logic                  wr_fire, rd_fire;
    logic [DATA_WIDTH-1:0] rd_old, rd_merged;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    sram_init_seq #(
        .DEPTH     (DEPTH),
        .INIT_ZERO (INIT_ZERO),
        .AW        (AW)
    ) u_init_seq (
        .clock      (clock),
        .reset      (reset),
        .init_done  (init_done),
        .sweep_en   (sweep_en),
        .sweep_addr (sweep_addr)
    );

    // init_done is registered, so it can still read high in the reset cycle itself.
    assign wr_fire = W0_en & init_done & ~reset;
    assign rd_fire = R0_en & init_done & ~reset;

    // Array storage is intentionally not reset; only the sweep clears it.
    always_ff @(posedge clock) begin
        if (sweep_en) begin
            ram[sweep_addr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (W0_mask[i]) begin
                    ram[W0_addr][i*G +: G] <= W0_data[i*G +: G];
                end
            end
        end
    end

    assign rd_old = ram[R0_addr];

    // Write-first forwarding: overlay only the granules being written this cycle.
    always_comb begin
        rd_merged = rd_old;
        if (BYPASS != 0 && wr_fire && (W0_addr == R0_addr)) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (W0_mask[i]) begin
                    rd_merged[i*G +: G] = W0_data[i*G +: G];
                end
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        always_ff @(posedge clock) begin
            if (reset) begin
                dat_q  <= '0;
                done_q <= 1'b0;
            end else begin
                done_q <= rd_fire;
                if (rd_fire) begin
                    dat_q <= rd_merged;
                end
            end
        end
    end else begin : g_lat2
        // Data is captured at the first stage so a later write cannot disturb it.
        logic                  s1_vld;
        logic [DATA_WIDTH-1:0] s1_dat;

        always_ff @(posedge clock) begin
            if (reset) begin
                s1_vld <= 1'b0;
                s1_dat <= '0;
                dat_q  <= '0;
                done_q <= 1'b0;
            end else begin
                s1_vld <= rd_fire;
                if (rd_fire) begin
                    s1_dat <= rd_merged;
                end
                done_q <= s1_vld;
                if (s1_vld) begin
                    dat_q <= s1_dat;
                end
            end
        end
    end

`ifdef SRAM_GARBAGE_READ_EN
    logic [31:0]           lfsr_q;
    logic [DATA_WIDTH-1:0] garbage;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= SRAM_LFSR_SEED;
        end else begin
            lfsr_q <= sram_lfsr_next(lfsr_q);
        end
    end

    always_comb begin
        garbage = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            garbage[i] = lfsr_q[i % 32];
        end
    end

    assign R0_data = done_q ? dat_q : garbage;
`else
    logic unused_done;
    assign unused_done = done_q;
    assign R0_data     = dat_q;
`endif

endmodule
